// File: rtl/vga_sync_gen_if.sv
// -----------------------------------------------------------------------------
// vga_sync_gen_if
// Bundle of the VGA timing signals between the sync generator and its
// consumers (pixel pipeline, DAC).
//
// Signals
//   en          : count enable from the consumer side; low freezes the timing
//   hsync       : horizontal sync, active low
//   vsync       : vertical sync, active low
//   video_on    : high inside the visible area
//   pixel_x     : current horizontal position (0..H_TOTAL-1)
//   pixel_y     : current vertical position (0..V_TOTAL-1)
//   line_start  : high while pixel_x == 0
//   frame_start : high while pixel_x == 0 and pixel_y == 0
//   vga_blank_n : DAC blank (active low), identical to video_on
//   vga_sync_n  : DAC sync-on-green, tied low
//
// Handshake: there is no valid/ready pair. Every output is valid on every
// cycle and describes the pixel currently addressed by pixel_x/pixel_y; the
// position advances on a vga_clk rising edge only when en is high.
//
// Modports
//   master : the sync generator (drives timing, samples en)
//   slave  : a consumer (drives en, samples timing)
// -----------------------------------------------------------------------------
interface vga_sync_gen_if;
   logic       en;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       line_start;
   logic       frame_start;
   logic       vga_blank_n;
   logic       vga_sync_n;

   modport master (
      input  en,
      output hsync, vsync, video_on, pixel_x, pixel_y,
             line_start, frame_start, vga_blank_n, vga_sync_n
   );

   modport slave (
      output en,
      input  hsync, vsync, video_on, pixel_x, pixel_y,
             line_start, frame_start, vga_blank_n, vga_sync_n
   );
endinterface

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// VGA timing generator. Two position counters (h_cnt, v_cnt) are the only
// state; every other output is decoded combinationally from them so all
// outputs line up with pixel_x/pixel_y in the same cycle.
//
// Ports
//   vga_clk : pixel clock, all state updates on its rising edge
//   rst     : asynchronous, active-high reset; forces position (0,0)
//   vga     : vga_sync_gen_if.master (en in; sync, blank, position out)
//
// Parameters give the horizontal/vertical visible, front porch, sync and
// back porch lengths; totals must stay below 1024 to fit the 10-bit counters.
// -----------------------------------------------------------------------------
module vga_sync_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input logic            vga_clk,
   input logic            rst,
   vga_sync_gen_if.master vga
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Boundaries pre-sized to the counter width so compares are width-exact.
   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
   localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
   localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   logic       video_on_w;

   // Next position: the line counter only moves on the clock that wraps the
   // pixel counter, so vsync always spans whole lines.
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (vga.en) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
               v_cnt_d = '0;
            end else begin
               v_cnt_d = v_cnt_q + 10'd1;
            end
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end
      end
   end

   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Decode straight from the counters: because reset clears the counters
   // asynchronously, these outputs also change immediately on reset.
   assign video_on_w      = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);

   assign vga.pixel_x     = h_cnt_q;
   assign vga.pixel_y     = v_cnt_q;
   assign vga.video_on    = video_on_w;
   assign vga.vga_blank_n = video_on_w;
   assign vga.vga_sync_n  = 1'b0;
   assign vga.hsync       = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
   assign vga.vsync       = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
   assign vga.line_start  = (h_cnt_q == 10'd0);
   assign vga.frame_start = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
// Bench for vga_sync_gen using a reduced timing so whole frames fit in a short
// run. The reference model counts enabled clocks since reset (t) and derives
// the expected raster position and every output from it with plain
// arithmetic: x = t mod H_TOTAL, y = (t div H_TOTAL) mod V_TOTAL.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

   localparam int HV = 64, HF = 8, HS = 12, HB = 6;
   localparam int VV = 48, VF = 4, VS = 2,  VB = 6;
   localparam int H_TOTAL = HV + HF + HS + HB;
   localparam int V_TOTAL = VV + VF + VS + VB;
   localparam int FRAME   = H_TOTAL * V_TOTAL;

   // ---------------- clock / reset ----------------
   logic vga_clk = 1'b0;
   logic rst     = 1'b1;
   always #5 vga_clk = ~vga_clk;

   vga_sync_gen_if vif ();

   vga_sync_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut (
      .vga_clk (vga_clk),
      .rst     (rst),
      .vga     (vif.master)
   );

   // ---------------- scoreboard / model ----------------
   int checks   = 0;
   int failures = 0;
   int t        = 0;   // enabled clocks since reset
   logic en_r   = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)",
                  tag, obs, exp, t, $time);
      end
   endtask

   function automatic int mx();
      return t % H_TOTAL;
   endfunction

   function automatic int my();
      return (t / H_TOTAL) % V_TOTAL;
   endfunction

   // Compare every output against the model position.
   task automatic check_all(input string tag);
      int  x, y;
      logic e_vid, e_hs, e_vs;
      x = mx();
      y = my();
      e_vid = (x < HV) && (y < VV);
      e_hs  = !((x >= HV + HF) && (x < HV + HF + HS));
      e_vs  = !((y >= VV + VF) && (y < VV + VF + VS));
      check_eq({tag, ".pixel_x"},     32'(vif.pixel_x),     32'(x));
      check_eq({tag, ".pixel_y"},     32'(vif.pixel_y),     32'(y));
      check_eq({tag, ".video_on"},    32'(vif.video_on),    32'(e_vid));
      check_eq({tag, ".blank_n"},     32'(vif.vga_blank_n), 32'(e_vid));
      check_eq({tag, ".sync_n"},      32'(vif.vga_sync_n),  32'(0));
      check_eq({tag, ".hsync"},       32'(vif.hsync),       32'(e_hs));
      check_eq({tag, ".vsync"},       32'(vif.vsync),       32'(e_vs));
      check_eq({tag, ".line_start"},  32'(vif.line_start),  32'(x == 0));
      check_eq({tag, ".frame_start"}, 32'(vif.frame_start), 32'(x == 0 && y == 0));
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_en(input logic v);
      en_r   = v;
      vif.en = v;
   endtask

   // One clock: update the model, then sample 1 time unit after the edge.
   task automatic tick(input string tag);
      @(posedge vga_clk);
      if (!rst && en_r) t++;
      #1;
      check_all(tag);
   endtask

   // Advance with en high until the model reaches (x,y); bounded.
   task automatic run_to(input int x, input int y, input string tag);
      int n = 0;
      set_en(1'b1);
      while (!(mx() == x && my() == y) && n < 2 * FRAME) begin
         tick(tag);
         n++;
      end
      check_eq({tag, ".reached"}, 32'(mx() == x && my() == y), 32'(1));
   endtask

   // ---------------- stimulus ----------------
   int n_fs, n_vs_low, n_vid;

   initial begin
      vif.en = 1'b0;

      // Reset state while rst is held.
      #12;
      check_all("reset");

      // Release with en high: first edge must give pixel_x = 1.
      set_en(1'b1);
      rst = 1'b0;
      tick("release");

      // First line: visible end, hsync window, wrap into line 1.
      for (int i = 1; i < H_TOTAL; i++) tick("line0");
      check_eq("line0.x_wrap", 32'(vif.pixel_x), 32'(0));
      check_eq("line0.y_next", 32'(vif.pixel_y), 32'(1));

      // Full frame statistics from (0,0) for FRAME samples.
      run_to(0, 0, "to_frame");
      n_fs = 0; n_vs_low = 0; n_vid = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (vif.frame_start) n_fs++;
         if (!vif.vsync)      n_vs_low++;
         if (vif.video_on)    n_vid++;
         if (i != FRAME - 1) tick("frame");
      end
      check_eq("frame.last_x", 32'(vif.pixel_x), 32'(H_TOTAL - 1));
      check_eq("frame.last_y", 32'(vif.pixel_y), 32'(V_TOTAL - 1));
      check_eq("frame.fs_count",   32'(n_fs),     32'(1));
      check_eq("frame.vsync_low",  32'(n_vs_low), 32'(VS * H_TOTAL));
      check_eq("frame.video_on",   32'(n_vid),    32'(HV * VV));

      // Wrap boundary (last pixel -> origin).
      tick("wrap");
      check_eq("wrap.frame_start", 32'(vif.frame_start), 32'(1));

      // Random enable pattern; frozen cycles must hold every output.
      for (int i = 0; i < 3 * FRAME; i++) begin
         set_en($urandom_range(0, 3) != 0);
         tick("rand_en");
      end

      // Directed freeze at (20,10) for 10 clocks.
      run_to(20, 10, "to_freeze");
      set_en(1'b0);
      for (int i = 0; i < 10; i++) tick("freeze");
      check_eq("freeze.hold_x", 32'(vif.pixel_x), 32'(20));
      set_en(1'b1);
      tick("resume");
      check_eq("resume.x", 32'(vif.pixel_x), 32'(21));

      // Freeze at a line start: line_start must stay high.
      run_to(0, 5, "to_ls");
      set_en(1'b0);
      for (int i = 0; i < 4; i++) tick("ls_hold");
      check_eq("ls_hold.line_start", 32'(vif.line_start), 32'(1));
      set_en(1'b1);

      // Asynchronous reset during hsync and vsync.
      run_to(HV + HF + 4, VV + VF + VS - 1, "to_sync");
      check_eq("pre_rst.hsync", 32'(vif.hsync), 32'(0));
      check_eq("pre_rst.vsync", 32'(vif.vsync), 32'(0));
      #2;
      rst = 1'b1;
      t   = 0;
      #1;   // still between clock edges
      check_all("async_rst");
      tick("rst_hold");
      tick("rst_hold");
      rst = 1'b0;
      tick("rst_release");
      check_eq("rst_release.x", 32'(vif.pixel_x), 32'(1));

      // Short random tail.
      for (int i = 0; i < FRAME / 2; i++) begin
         set_en($urandom_range(0, 1) == 1);
         tick("tail");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
